// File: rtl/instr_mem_loader_if.sv
// Byte-stream and instruction-memory write bus between the boot loader and its environment.
// master: stream source / memory side; slave: the loader.
interface instr_mem_loader_if;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;

    modport master (
        output byte_data,
        output byte_valid,
        input  byte_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_data
    );

    modport slave (
        input  byte_data,
        input  byte_valid,
        output byte_ready,
        output mem_we,
        output mem_addr,
        output mem_data
    );
endinterface

// File: rtl/instr_mem_loader.sv
// Boot-time program loader: packs a big-endian byte stream into 32-bit words, writes them to
// consecutive instruction-memory slots and holds the CPU until the load completes.
module instr_mem_loader #(
    parameter int unsigned WORDS = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [CNT_W-1:0]     length_i,
    instr_mem_loader_if.slave    bus,
    output logic                 cpu_hold_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [CNT_W-1:0]     word_cnt_o
);

    typedef enum logic [1:0] {StIdle, StLoad, StWrite, StDone} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [1:0]       byte_cnt_q, byte_cnt_d;
    logic [31:0]      shift_q, shift_d;

    logic [CNT_W-1:0] len_clamped;
    logic [CNT_W-1:0] word_cnt_inc;

    assign len_clamped  = (length_i > CNT_W'(WORDS)) ? CNT_W'(WORDS) : length_i;
    assign word_cnt_inc = word_cnt_q + CNT_W'(1);

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start_i) begin
                    len_d      = len_clamped;
                    word_cnt_d = '0;
                    byte_cnt_d = '0;
                    shift_d    = '0;
                    state_d    = (len_clamped == '0) ? StDone : StLoad;
                end
            end
            StLoad: begin
                // byte_ready is high throughout LOAD, so valid alone means accepted
                if (bus.byte_valid) begin
                    shift_d    = {shift_q[23:0], bus.byte_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                word_cnt_d = word_cnt_inc;
                byte_cnt_d = '0;
                state_d    = (word_cnt_inc == len_q) ? StDone : StLoad;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            len_q      <= '0;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
            shift_q    <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
        end
    end

    // Every output is decoded from registered state only.
    assign bus.byte_ready = (state_q == StLoad);
    assign bus.mem_we     = (state_q == StWrite);
    assign bus.mem_addr   = 32'({word_cnt_q, 2'b00});
    assign bus.mem_data   = shift_q;
    assign cpu_hold_o     = (state_q != StDone);
    assign busy_o         = (state_q == StLoad) || (state_q == StWrite);
    assign done_o         = (state_q == StDone);
    assign word_cnt_o     = word_cnt_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: expected writes are derived from the byte stream and
// queued at issue time; an independent monitor pops and compares every memory write.
module tb_instr_mem_loader;

    localparam int WORDS = 32;
    localparam int CNT_W = 6;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] length;
    logic             cpu_hold;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] word_cnt;

    instr_mem_loader_if bus();

    instr_mem_loader #(
        .WORDS (WORDS),
        .CNT_W (CNT_W)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .length_i   (length),
        .bus        (bus.slave),
        .cpu_hold_o (cpu_hold),
        .busy_o     (busy),
        .done_o     (done),
        .word_cnt_o (word_cnt)
    );

    always #5 clk = ~clk;

    wr_t        exp_q[$];
    logic [7:0] stim_q[$];
    int         n_vec = 0;
    int         n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every write must match the head of the expected queue and last one cycle.
    initial begin
        logic prev_we;
        wr_t  e;
        prev_we = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.mem_we === 1'b1) begin
                check("we_single_cycle", 32'(prev_we), 32'd0);
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_write: addr %0h data %0h, no write expected",
                             bus.mem_addr, bus.mem_data);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", bus.mem_addr, e.addr);
                    check("wr_data", bus.mem_data, e.data);
                end
            end
            prev_we = bus.mem_we;
        end
    end

    // gap: 0 continuous valid, 1 valid on alternate cycles, 2 random gaps.
    task automatic load(input int len, input int gap, input int extra, input bit timed,
                        input bit pulse);
        int  eff;
        int  idx;
        int  cyc;
        bit  v;
        bit  acc;
        wr_t w;
        eff = (len > WORDS) ? WORDS : len;
        while (stim_q.size() < 4 * eff + extra) stim_q.push_back(8'($urandom));
        for (int k = 0; k < eff; k++) begin
            w.addr = 32'(4 * k);
            w.data = {stim_q[4*k], stim_q[4*k+1], stim_q[4*k+2], stim_q[4*k+3]};
            exp_q.push_back(w);
        end
        start  = 1'b1;
        length = CNT_W'(len);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("ready_after_start", 32'(bus.byte_ready), 32'(eff > 0));
        check("busy_after_start", 32'(busy), 32'(eff > 0));
        cyc = 1;
        idx = 0;
        while (done !== 1'b1 && cyc < 3000) begin
            start = pulse && (cyc == 3);
            if (pulse && cyc == 3) length = CNT_W'(5);
            case (gap)
                0:       v = 1'b1;
                1:       v = (cyc % 2) == 0;
                default: v = $urandom_range(0, 2) != 0;
            endcase
            bus.byte_valid = v && (idx < stim_q.size());
            bus.byte_data  = bus.byte_valid ? stim_q[idx] : 8'($urandom);
            acc = bus.byte_valid && bus.byte_ready;
            check("hold_during_load", 32'(cpu_hold), 32'd1);
            @(posedge clk);
            #1;
            if (acc) idx++;
            cyc++;
        end
        start = 1'b0;
        bus.byte_valid = 1'b0;
        check("done", 32'(done), 32'd1);
        if (timed) check("done_cycle", 32'(cyc), 32'(1 + 5 * eff));
        check("bytes_accepted", 32'(idx), 32'(4 * eff));
        check("word_cnt", 32'(word_cnt), 32'(eff));
        check("hold_released", 32'(cpu_hold), 32'd0);
        check("busy_done", 32'(busy), 32'd0);
        check("ready_done", 32'(bus.byte_ready), 32'd0);
        stim_q.delete();
    endtask

    task automatic push_prog();
        logic [7:0] prog [8];
        prog = '{8'h8C, 8'h01, 8'h00, 8'h04, 8'h20, 8'h02, 8'h00, 8'h05};
        stim_q.delete();
        for (int k = 0; k < 8; k++) stim_q.push_back(prog[k]);
    endtask

    initial begin
        rst            = 1'b1;
        start          = 1'b0;
        length         = '0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(bus.byte_ready), 32'd0);
        check("rst_we", 32'(bus.mem_we), 32'd0);
        check("rst_addr", bus.mem_addr, 32'd0);
        check("rst_data", bus.mem_data, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_word_cnt", 32'(word_cnt), 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            check("idle_hold", 32'(cpu_hold), 32'd1);
            check("idle_done", 32'(done), 32'd0);
            check("idle_we", 32'(bus.mem_we), 32'd0);
            check("idle_ready", 32'(bus.byte_ready), 32'd0);
        end

        push_prog();
        load(2, 0, 0, 1'b1, 1'b0);
        push_prog();
        load(2, 1, 0, 1'b0, 1'b0);
        load(40, 0, 8, 1'b1, 1'b0);
        load(0, 0, 4, 1'b1, 1'b0);
        load(3, 0, 0, 1'b1, 1'b1);

        // Abort after two bytes of the first word; nothing may be written for it.
        start  = 1'b1;
        length = CNT_W'(1);
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bus.byte_valid = 1'b1;
            bus.byte_data  = 8'($urandom);
            @(posedge clk);
            #1;
        end
        bus.byte_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_ready", 32'(bus.byte_ready), 32'd0);
        check("abort_hold", 32'(cpu_hold), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_word_cnt", 32'(word_cnt), 32'd0);
        check("abort_data", bus.mem_data, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        load(1, 0, 0, 1'b1, 1'b0);

        for (int r = 0; r < 6; r++) begin
            load(int'($urandom_range(0, 40)), 2, int'($urandom_range(0, 6)), 1'b0, 1'b0);
            repeat (int'($urandom_range(0, 3))) @(posedge clk);
            #1;
        end

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
